// File: rtl/fragmented_replicator_pkg.sv
// fragmented_replicator_pkg: width helpers and output slot mappings for the fragment replicator.
package fragmented_replicator_pkg;
  function automatic int frag_w(input int wire_l);
    return 2 ** wire_l;
  endfunction
  function automatic int in_w(input int bus_l, input int wire_l);
    return 2 ** (bus_l + wire_l);
  endfunction
  function automatic int out_w(input int bus_l, input int way_l, input int wire_l);
    return 2 ** (bus_l + way_l + wire_l);
  endfunction
  function automatic int slot_contig(input int f, input int w, input int way_l);
    return f * (2 ** way_l) + w;
  endfunction
  function automatic int slot_inter(input int f, input int w, input int bus_l);
    return w * (2 ** bus_l) + f;
  endfunction
endpackage

// File: rtl/fragmented_replicator_if.sv
// fragmented_replicator_if: valid-qualified input bus and widened registered output bus.
interface fragmented_replicator_if import fragmented_replicator_pkg::*; #(
    parameter int WIRE = 3,
    parameter int WAY  = 1,
    parameter int BUS  = 1
);
    logic                            in_valid;
    logic [in_w(BUS, WIRE)-1:0]      in;
    logic                            out_valid;
    logic [out_w(BUS, WAY, WIRE)-1:0] out;
    modport master (output in_valid, output in, input out_valid, input out);
    modport slave  (input in_valid, input in, output out_valid, output out);
endinterface

// File: rtl/fragment_replicate.sv
// fragment_replicate: combinational 2**WAY copies of one 2**WIRE-bit fragment.
module fragment_replicate #(
    parameter int WIRE = 3,
    parameter int WAY  = 1
) (
    input  logic [2**WIRE-1:0]       frag,
    output logic [2**(WAY+WIRE)-1:0] copies
);
    assign copies = {(2 ** WAY){frag}};
endmodule

// File: rtl/fragmented_replicator.sv
// fragmented_replicator: replicates each input fragment 2**WAY times into a registered bus.
// FRAGMENTED_REPLICATOR_INTERLEAVE_EN selects whole-bus interleave instead of contiguous copies.
module fragmented_replicator import fragmented_replicator_pkg::*; #(
    parameter int WIRE = 3,
    parameter int WAY  = 1,
    parameter int BUS  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fragmented_replicator_if.slave io
);
    localparam int FW = frag_w(WIRE);
    localparam int NF = 2 ** BUS;
    localparam int NC = 2 ** WAY;
    localparam int OW = out_w(BUS, WAY, WIRE);
`ifdef FRAGMENTED_REPLICATOR_INTERLEAVE_EN
    localparam bit ILV = 1'b1;
`else
    localparam bit ILV = 1'b0;
`endif
    logic [OW-1:0] out_d;
    genvar f, w;
    for (f = 0; f < NF; f++) begin : g_frag
        logic [NC*FW-1:0] copies;
        fragment_replicate #(.WIRE(WIRE), .WAY(WAY)) u_rep (
            .frag   (io.in[f*FW +: FW]),
            .copies (copies)
        );
        for (w = 0; w < NC; w++) begin : g_copy
            localparam int S = ILV ? slot_inter(f, w, BUS) : slot_contig(f, w, WAY);
            assign out_d[S*FW +: FW] = copies[w*FW +: FW];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out       <= '0;
            io.out_valid <= 1'b0;
        end else begin
            io.out_valid <= io.in_valid;
            if (io.in_valid) io.out <= out_d;
        end
    end
endmodule

// File: tb/tb_fragmented_replicator.sv
// tb_fragmented_replicator: directed literals plus random stream against a slot-arithmetic model.
module tb_fragmented_replicator;
    localparam int WIRE = 3, WAY = 1, BUS = 1;
    localparam int FW = 8, IW = 16, OW = 32, NF = 2, NC = 2;
`ifdef FRAGMENTED_REPLICATOR_INTERLEAVE_EN
    localparam logic [31:0] L_BASIC = 32'hB4AA_B4AA, L_S0 = 32'h0102_0102, L_S1 = 32'hFF00_FF00;
`else
    localparam logic [31:0] L_BASIC = 32'hB4B4_AAAA, L_S0 = 32'h0101_0202, L_S1 = 32'hFFFF_0000;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    fragmented_replicator_if #(.WIRE(WIRE), .WAY(WAY), .BUS(BUS)) bif ();
    fragmented_replicator_if #(.WIRE(3), .WAY(0), .BUS(1)) wif ();
    fragmented_replicator_if #(.WIRE(3), .WAY(1), .BUS(0)) oif ();
    assign wif.in_valid = bif.in_valid;
    assign wif.in       = bif.in;
    assign oif.in_valid = bif.in_valid;
    assign oif.in       = bif.in[7:0];

    fragmented_replicator #(.WIRE(WIRE), .WAY(WAY), .BUS(BUS)) dut (.clk(clk), .rst_n(rst_n), .io(bif));
    fragmented_replicator #(.WIRE(3), .WAY(0), .BUS(1)) dut_way0 (.clk(clk), .rst_n(rst_n), .io(wif));
    fragmented_replicator #(.WIRE(3), .WAY(1), .BUS(0)) dut_bus0 (.clk(clk), .rst_n(rst_n), .io(oif));

    always #5 clk = ~clk;

    // Each output slot looks up its source fragment by slot arithmetic alone.
    function automatic logic [OW-1:0] model(input logic [IW-1:0] d);
        logic [OW-1:0] r;
        int f;
        r = '0;
        for (int s = 0; s < NF * NC; s++) begin
`ifdef FRAGMENTED_REPLICATOR_INTERLEAVE_EN
            f = s % NF;
`else
            f = s / NC;
`endif
            r[s*FW +: FW] = d[f*FW +: FW];
        end
        return r;
    endfunction

    logic [OW-1:0] exp_out;
    logic          exp_v;
    logic [15:0]   exp_w0, exp_b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out <= '0;
            exp_v   <= 1'b0;
            exp_w0  <= '0;
            exp_b0  <= '0;
        end else begin
            exp_v <= bif.in_valid;
            if (bif.in_valid) begin
                exp_out <= model(bif.in);
                exp_w0  <= bif.in;
                exp_b0  <= {2{bif.in[7:0]}};
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_out", bif.out, exp_out);
        chk("model_valid", {31'b0, bif.out_valid}, {31'b0, exp_v});
        chk("way0_out", {16'b0, wif.out}, {16'b0, exp_w0});
        chk("bus0_out", {16'b0, oif.out}, {16'b0, exp_b0});
        chk("sweep_valid", {30'b0, wif.out_valid, oif.out_valid}, {30'b0, exp_v, exp_v});
    end

    initial begin
        rst_n = 1'b0;
        bif.in_valid = 1'b1;
        bif.in = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", bif.out, 32'h0);
            chk("rst_valid", {31'b0, bif.out_valid}, 32'h0);
        end
        rst_n = 1'b1;
        #1 chk("release_no_change", bif.out, 32'h0);
        @(negedge clk);
        chk("first_edge", bif.out, 32'hFFFF_FFFF);
        bif.in = 16'hB4AA;
        @(negedge clk);
        chk("basic", bif.out, L_BASIC);
        chk("basic_valid", {31'b0, bif.out_valid}, 32'h1);
        chk("way0_basic", {16'b0, wif.out}, 32'h0000_B4AA);
        chk("bus0_basic", {16'b0, oif.out}, 32'h0000_AAAA);
        bif.in_valid = 1'b0;
        bif.in = 16'h1234;
        @(negedge clk);
        chk("hold", bif.out, L_BASIC);
        chk("hold_valid", {31'b0, bif.out_valid}, 32'h0);
        bif.in_valid = 1'b1;
        bif.in = 16'h0102;
        @(negedge clk);
        chk("stream0", bif.out, L_S0);
        bif.in = 16'hFF00;
        @(negedge clk);
        chk("stream1", bif.out, L_S1);
        chk("stream1_valid", {31'b0, bif.out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_out", bif.out, 32'h0);
        chk("async_valid", {31'b0, bif.out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bif.in = 16'($urandom);
            bif.in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
